// File: rtl/jkff_pkg.sv
// Command encodings shared by the JK command arbiter and its flop bank,
// plus the command-to-J/K mapping.
package jkff_pkg;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  // Returns {J,K} for the addressed flop.
  function automatic logic [1:0] cmd_to_jk(input logic [1:0] cmd);
    logic [1:0] jk;
    case (cmd)
      CMD_RESET:  jk = 2'b01;
      CMD_SET:    jk = 2'b10;
      CMD_TOGGLE: jk = 2'b11;
      default:    jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jkff_bank.sv
// Bank of independent JK flip-flops with asynchronous clear.
module jkff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = ~q_q[i];
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jkff_cmd_arbiter.sv
// Round-robin arbiter sharing one JK flop bank among NREQ requesters;
// one registered issue stage drives J/K, ack/err pulse when q is updated.
module jkff_cmd_arbiter
  import jkff_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [2*NREQ-1:0]  req_cmd,
  input  logic [AW*NREQ-1:0] req_addr,
  output logic [WIDTH-1:0]   q,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            stg_vld_q, stg_vld_d;
  logic [1:0]      stg_cmd_q, stg_cmd_d;
  logic [AW-1:0]   stg_addr_q, stg_addr_d;
  logic [IDW-1:0]  stg_id_q, stg_id_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] grant;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic [1:0]      jk;
  logic            oor;

  // Scan from the pointer, wrapping; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
    grant = '0;
    if (found) grant[win] = 1'b1;
  end

  assign req_ready = grant & {NREQ{rst_n}};

  always_comb begin
    ptr_d      = ptr_q;
    stg_vld_d  = found;
    stg_cmd_d  = req_cmd[2*int'(win) +: 2];
    stg_addr_d = req_addr[AW*int'(win) +: AW];
    stg_id_d   = win;
    if (found) ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
  end

  always_comb begin
    jk    = cmd_to_jk(stg_cmd_q);
    j_vec = '0;
    k_vec = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (stg_vld_q && stg_addr_q == AW'(b)) begin
        j_vec[b] = jk[1];
        k_vec[b] = jk[0];
      end
    end
  end

  // Out-of-range addresses match no flop; the command is still consumed.
  assign oor = {1'b0, stg_addr_q} >= (AW+1)'(WIDTH);

  always_comb begin
    ack_d = '0;
    err_d = '0;
    if (stg_vld_q) begin
      ack_d[stg_id_q] = 1'b1;
      err_d[stg_id_q] = oor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_cmd_q  <= CMD_HOLD;
      stg_addr_q <= '0;
      stg_id_q   <= '0;
      ack_q      <= '0;
      err_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      stg_vld_q  <= stg_vld_d;
      stg_cmd_q  <= stg_cmd_d;
      stg_addr_q <= stg_addr_d;
      stg_id_q   <= stg_id_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  jkff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j_vec),
    .k     (k_vec),
    .q     (q)
  );

  assign ack = ack_q;
  assign err = err_q;

endmodule

// File: tb/tb_jkff_cmd_arbiter.sv
// Scoreboard bench for jkff_cmd_arbiter: round-robin/JK reference model,
// directed scenarios followed by randomized traffic.
module tb_jkff_cmd_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 6;
  localparam int AW    = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_cmd;
  logic [AW*NREQ-1:0] req_addr;
  logic [WIDTH-1:0]   q;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    err;

  jkff_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .q         (q),
    .ack       (ack),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int               due;
    int               id;
    bit               er;
    logic [WIDTH-1:0] qv;
  } exp_t;

  exp_t             sbq[$];
  int               grant_log[$];
  int               ack_cnt[NREQ];
  int               m_ptr = 0;
  logic [WIDTH-1:0] m_q = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: arbitration, JK bank contents, expected responses.
  int               w, a;
  logic [1:0]       mc;
  logic [NREQ-1:0]  exp_rdy;
  exp_t             ne;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0;
      m_q   = '0;
      sbq.delete();
      check("ready_in_reset", req_ready, 0);
      check("ack_in_reset", ack, 0);
      check("q_in_reset", q, 0);
    end else begin
      w = -1;
      for (int i = 0; i < NREQ; i++)
        if (w < 0 && req_valid[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (w >= 0) begin
        mc = req_cmd[2*w +: 2];
        a  = int'(req_addr[AW*w +: AW]);
        if (a < WIDTH) begin
          case (mc)
            2'b01: m_q[a] = 1'b0;
            2'b10: m_q[a] = 1'b1;
            2'b11: m_q[a] = ~m_q[a];
            default: ;
          endcase
        end
        ne.due = cyc + 2;
        ne.id  = w;
        ne.er  = (a >= WIDTH);
        ne.qv  = m_q;
        sbq.push_back(ne);
        grant_log.push_back(w);
        m_ptr = (w + 1) % NREQ;
      end
    end
  end

  // Monitor: compare every DUT response against the scoreboard.
  exp_t e;
  logic [NREQ-1:0] oh;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", ack, 0);
        end else begin
          e  = sbq.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          check("ack", ack, oh);
          check("err", err, e.er ? oh : '0);
          check("q", q, e.qv);
          check("latency", cyc, e.due);
          ack_cnt[e.id]++;
        end
      end else begin
        if (err != '0) check("err_without_ack", err, 0);
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e  = sbq.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          check("missing_ack", ack, oh);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [1:0] c, input int ad);
    req_valid[i]         = v;
    req_cmd[2*i +: 2]    = c;
    req_addr[AW*i +: AW] = AW'(ad);
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input int i, input logic [1:0] c, input int ad);
    bit g;
    g = 1'b0;
    set_req(i, 1'b1, c, ad);
    for (int n = 0; n < 50 && !g; n++) begin
      #1;
      g = req_ready[i];
      tick();
    end
    if (!g) check("grant_timeout", 0, 1);
    req_valid[i] = 1'b0;
  endtask

  logic [1:0]       seq_cmd [5];
  logic             seq_q   [5];
  logic [WIDTH-1:0] q_save;
  int               ack2_before, glog_base;
  int               ackc_base[NREQ];
  logic [NREQ-1:0]  gl;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    req_addr  = '0;
    repeat (3) tick();
    check("rst_q", q, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single SET from requester 0 on bit 3
    set_req(0, 1'b1, 2'b10, 3);
    #1 check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("t1_q", q, 6'h08);
    check("t1_ack", ack, 4'b0001);
    check("t1_err", err, 0);

    // JK sequence on bit 5 from requester 2
    seq_cmd = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01};
    seq_q   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    ack2_before = ack_cnt[2];
    for (int k = 0; k < 7; k++) begin
      if (k < 5) set_req(2, 1'b1, seq_cmd[k], 5);
      else       req_valid[2] = 1'b0;
      if (k >= 2) check("seq_q5", q[5], seq_q[k-2]);
      tick();
    end
    tick();
    check("seq_acks", ack_cnt[2] - ack2_before, 5);

    // Round-robin fairness, toggles on bits 0..3
    reset_dut();
    tick();
    glog_base = grant_log.size();
    for (int i = 0; i < NREQ; i++) ackc_base[i] = ack_cnt[i];
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b11, i);
    repeat (8) tick();
    req_valid = '0;
    repeat (3) tick();
    check("rr_grants", grant_log.size() - glog_base, 8);
    for (int k = 0; k < 8 && glog_base + k < grant_log.size(); k++)
      check("rr_order", grant_log[glog_base + k], k % NREQ);
    check("rr_q", q[3:0], 4'b0000);
    for (int i = 0; i < NREQ; i++) check("rr_ackcnt", ack_cnt[i] - ackc_base[i], 2);

    // Pointer wrap: grant 2 leaves pointer at 3
    issue(2, 2'b00, 0);
    set_req(3, 1'b1, 2'b10, 1);
    set_req(0, 1'b1, 2'b10, 2);
    #1 check("wrap_first", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    #1 check("wrap_second", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    repeat (3) tick();

    // Out-of-range addresses (WIDTH=6)
    q_save = q;
    set_req(1, 1'b1, 2'b10, 7);
    #1 check("oor_ready", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    check("oor_ack", ack, 4'b0010);
    check("oor_err", err, 4'b0010);
    check("oor_q", q, q_save);
    issue(3, 2'b11, 6);
    repeat (3) tick();

    // Reset while a toggle is in the issue stage
    reset_dut();
    tick();
    set_req(0, 1'b1, 2'b11, 0);
    tick();
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1 check("mid_q", q, 0);
    tick();
    tick();
    check("mid_ack", ack, 0);
    check("mid_q2", q, 0);
    rst_n = 1'b1;
    set_req(3, 1'b1, 2'b00, 0);
    set_req(0, 1'b1, 2'b00, 0);
    #1 check("mid_resume", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Randomized traffic with hold-until-grant and occasional drops
    gl = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !gl[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 6) begin
          set_req(i, 1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 7));
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #1 gl = req_ready & req_valid;
      tick();
    end
    req_valid = '0;
    repeat (5) tick();
    check("drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/jkff_cmd_arbiter.md
Name: jkff_cmd_arbiter

Overview:
Shares one bank of WIDTH JK flip-flops among NREQ requesters. Each requester issues HOLD, RESET, SET or TOGGLE commands against one bit index. A round-robin arbiter grants at most one command per cycle. A registered issue stage then drives the J/K pair of the addressed flop and reports per-requester completion. The block sits between control FSMs and the shared status/flag register built from JK flip-flops.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, number of JK flip-flops in the bank
AW, 3, bit-index width; must satisfy 2**AW >= WIDTH

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  command request per requester
req_ready  out  NREQ  grant; handshake completes when valid&&ready in the same cycle
req_cmd  in  2*NREQ  command, requester i at [2i+1:2i]; 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
req_addr  in  AW*NREQ  target bit index, requester i at [AW*i+AW-1:AW*i]
q  out  WIDTH  flip-flop bank outputs
ack  out  NREQ  one-cycle pulse; q already reflects the completed command
err  out  NREQ  one-cycle pulse, coincident with ack, when the accepted addr >= WIDTH

Behaviour:
- Reset (rst_n=0, asynchronous):
  - q=0, ack=0, err=0, issue stage invalid, rr pointer=0.
  - req_ready is forced to 0 while rst_n=0.
- Arbitration, combinational in cycle N:
  - Scan req_valid starting at the rr pointer, wrapping modulo NREQ. The first valid requester is the winner.
  - req_ready is one-hot for the winner, or all 0 if no request is valid.
  - req_ready never depends on the issue stage. Throughput is 1 command/cycle.
- Pointer update: on grant to requester i, rr pointer <= (i+1) mod NREQ. With no grant, the pointer holds.
- Requester rules: keep valid, cmd and addr stable until granted. Dropping valid before grant is legal; the request is lost and no ack is produced.
- Issue stage, registered at the end of cycle N: captures {valid=1, cmd, addr, requester id}.
- Cycle N+1: stage drives the addressed flop. HOLD gives J=0,K=0; RESET gives J=0,K=1; SET gives J=1,K=0; TOGGLE gives J=1,K=1. All other flops get J=K=0.
- The flop updates at the end of cycle N+1. q is visible in cycle N+2, and ack[id] pulses in N+2.
- Latency: 2 cycles from handshake to updated q and ack.
- Back-to-back commands to the same bit apply in grant order. A TOGGLE granted in N and a TOGGLE granted in N+1 give a net-zero change, visible by N+3.
- addr >= WIDTH: command is accepted and consumed, no flop changes, ack and err pulse together in N+2.
- HOLD: consumes a grant, q unchanged, ack pulses.
- Reset mid-operation: an in-flight stage entry is discarded and no ack is produced. After release, arbitration resumes from pointer 0.
- No combinational path from req_* to q, ack or err.

Decomposition:
- Shared package jkff_pkg:
  - command constants CMD_HOLD=2'b00, CMD_RESET=2'b01, CMD_SET=2'b10, CMD_TOGGLE=2'b11;
  - function cmd_to_jk returning {J,K}.
- Sub-module jkff_bank: WIDTH independent JK flops with J/K vector inputs, clk, rst_n, q vector.
  - Behaviour per flop: Q holds / resets / sets / toggles per JK truth table.
  - Asynchronous clear to 0.
- Arbiter, pointer and issue stage live in jkff_cmd_arbiter.

Test Plan:
- Reset then single SET: req 0 SET addr 3 in cycle 1 -> req_ready=0001 in cycle 1; q=8'h08 and ack=0001 in cycle 3; err=0.
- Full JK sequence on bit 5 from requester 2, one command per cycle: SET, HOLD, TOGGLE, TOGGLE, RESET -> q[5] observed 1,1,0,1,0, each two cycles after its grant; 5 acks to req 2.
- Round-robin fairness: all 4 requesters valid continuously with TOGGLE on distinct bits 0..3 -> grants 0,1,2,3,0,… one per cycle; after 8 grants q[3:0]=0000; each ack count=2.
- Pointer wrap: pointer at 3 (after grant to 2), req_valid=1001 -> grant 3 then 0.
- Out-of-range address with WIDTH=6, AW=3: req 1 SET addr 7 -> accepted; ack[1]=err[1]=1 in N+2; q unchanged.
- Reset mid-flight: grant TOGGLE bit 0 in cycle N, assert rst_n=0 in cycle N+1 -> q=0, no ack. After release, req 3 and req 0 valid -> req 0 granted first.
